hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RV32I core. It drives the hold input of the PC register (`stall_F`, 1 = hold PC), the hold and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers, and a writeback bubble. It detects load-use hazards, flushes on taken branches and jumps resolved in Execute, and freezes the pipeline while a data-memory access is outstanding, with a timeout. Saturating stall and flush counters feed performance monitoring.

## Interface
- `REG_W`, 5, register address width
- `MAX_WAIT`, 16, maximum memory wait cycles before timeout (≥2)
- `CNT_W`, 32, performance counter width

- `clk` input 1: clock, rising edge
- `rst` input 1: asynchronous, active-low reset (0 = reset)
- `rs1_D`, `rs2_D` input REG_W: source registers of the instruction in Decode
- `rd_E` input REG_W: destination register of the instruction in Execute
- `mem_read_E` input 1: the instruction in Execute is a load
- `branch_taken_E` input 1: taken branch or jump resolved in Execute
- `mem_req_M` input 1: Memory stage has an access in flight
- `mem_ready_M` input 1: data memory completes the access this cycle
- `stall_F` output 1: hold PC register
- `stall_D` output 1: hold IF/ID
- `stall_E` output 1: hold ID/EX
- `stall_M` output 1: hold EX/MEM
- `flush_D` output 1: clear IF/ID
- `flush_E` output 1: clear ID/EX
- `flush_W` output 1: bubble into MEM/WB
- `mem_err` output 1: sticky memory-timeout flag
- `stall_cnt` output CNT_W: cycles with `stall_F`=1, saturating
- `flush_cnt` output CNT_W: cycles with `flush_E`=1, saturating

## Operation
- FSM states: `RUN`, `MEM_WAIT`.
- Stall and flush outputs are combinational from the current state and inputs, so the PC and pipeline registers act on them at the same edge.
- Load-use hazard, `lu`: `mem_read_E` & (`rd_E`≠0) & (`rd_E`==`rs1_D` | `rd_E`==`rs2_D`).
- Memory miss, `mw`: `mem_req_M` & ~`mem_ready_M`.
- Priority, highest first:
  - `mw`: `stall_F`, `stall_D`, `stall_E` and `stall_M` are 1, `flush_W`=1, and all other flushes are 0.
  - `branch_taken_E`: `flush_D`=`flush_E`=1 and no stalls.
  - `lu`: `stall_F`=`stall_D`=1 and `flush_E`=1, inserting one bubble.
  - Otherwise all outputs are 0.
- A branch arriving during `mw` is deferred. Execute is frozen, so `branch_taken_E` stays asserted and takes effect in the release cycle.
- `lu` and `branch_taken_E` cannot both be true, because a load is not a branch. If they are, the branch wins.
- `RUN`→`MEM_WAIT` on `mw`. `MEM_WAIT`→`RUN` on `mem_ready_M` or on timeout.
- The internal counter `wait_cnt` clears on entry to `MEM_WAIT` and increments each cycle in `MEM_WAIT`.
- Timeout occurs when `wait_cnt`==`MAX_WAIT`-1 and `mem_ready_M`=0. In that cycle the stalls are released, `mem_err` is set at the next edge, and the state returns to `RUN`. `mem_err` clears only on reset.
- `stall_cnt` and `flush_cnt` increment by 1 per qualifying cycle and saturate at all-ones. They never wrap.

## Timing
- Reset, while `rst`=0: state `RUN`, `wait_cnt`=0, `mem_err`=0, both counters 0, all stalls 0, `flush_D`=`flush_E`=1, `flush_W`=0.
- Reset deasserted mid-wait: the controller restarts in `RUN` and re-evaluates `mw` combinationally.
- Load-use costs exactly 1 bubble. On the next edge the load moves to Memory and `lu` drops.
- Branch penalty is 2 squashed instructions, D and E, in one cycle.
- Memory wait of N cycles (N < `MAX_WAIT`): stalls are asserted for N cycles and drop in the cycle `mem_ready_M`=1.
- Counters update at the rising edge following the qualifying cycle.

## Structure
- Package `hazard_pkg`:
  - enum `hz_state_t` {`RUN`, `MEM_WAIT`}
  - default constants for `REG_W`, `MAX_WAIT`, `CNT_W`
- Sub-module `sat_counter #(W)`, instantiated twice:
  - ports: `clk`, `rst` (active-low async), `inc` in, `count` out
  - increments by 1 per `inc` cycle and holds at all-ones

## Test plan
- Load `x5` in E, `rs1_D`=5: exactly 1 cycle with `stall_F`=`stall_D`=`flush_E`=1, PC held 1 cycle, `stall_cnt`=1. Repeat with `rd_E`=0: no stall.
- `branch_taken_E`=1 for 1 cycle: `flush_D`=`flush_E`=1 that cycle, no stalls, `flush_cnt` increments by 1.
- `mem_req_M`=1 with `mem_ready_M` asserted after 3 cycles: `stall_F`..`stall_M` and `flush_W` high for 3 cycles, state back to `RUN`, `stall_cnt`=3.
- `mem_req_M`=1 with `mem_ready_M` never asserted, `MAX_WAIT`=16: stalls high for 16 cycles then released, `mem_err`=1 and stays 1 until `rst`=0.
- `branch_taken_E` asserted during a memory wait: no flush until the release cycle, then `flush_D`=`flush_E`=1. Separately, pulse `rst`=0 mid-wait: all outputs take their reset values asynchronously.
- `CNT_W`=4 with 20 consecutive stall cycles: `stall_cnt` holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the five-stage pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam int HZ_REG_W    = 5;
    localparam int HZ_MAX_WAIT = 16;
    localparam int HZ_CNT_W    = 32;

    // Packs the seven pipeline controls into one vector, ordered F..W
    function automatic logic [6:0] pack_ctl(
        input logic stall_f, input logic stall_d, input logic stall_e, input logic stall_m,
        input logic flush_d, input logic flush_e, input logic flush_w);
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; master is the datapath, slave the controller.
interface hazard_ctrl_if #(
    parameter int REG_W = hazard_pkg::HZ_REG_W,
    parameter int CNT_W = hazard_pkg::HZ_CNT_W
);
    logic [REG_W-1:0] rs1_D;
    logic [REG_W-1:0] rs2_D;
    logic [REG_W-1:0] rd_E;
    logic             mem_read_E;
    logic             branch_taken_E;
    logic             mem_req_M;
    logic             mem_ready_M;
    logic             stall_F;
    logic             stall_D;
    logic             stall_E;
    logic             stall_M;
    logic             flush_D;
    logic             flush_E;
    logic             flush_W;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_D, rs2_D, rd_E, mem_read_E, branch_taken_E, mem_req_M, mem_ready_M,
        input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
        input  mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_D, rs2_D, rd_E, mem_read_E, branch_taken_E, mem_req_M, mem_ready_M,
        output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
        output mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter for performance monitoring; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count qualifying cycles, holding once every bit is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= {W{1'b0}};
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use bubbles, branch squashes and memory-wait freeze with timeout.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = HZ_REG_W,
    parameter int MAX_WAIT = HZ_MAX_WAIT,
    parameter int CNT_W    = HZ_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    localparam int WC_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    hz_state_t        r_state;
    hz_state_t        w_next_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_mem_err;

    logic             w_lu;
    logic             w_mw;
    logic             w_timeout;
    logic             w_freeze;
    logic [6:0]       w_ctl;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;

    assign w_lu = bus.mem_read_E && (bus.rd_E != {REG_W{1'b0}}) &&
                  ((bus.rd_E == bus.rs1_D) || (bus.rd_E == bus.rs2_D));
    assign w_mw = bus.mem_req_M && !bus.mem_ready_M;
    // The timeout cycle releases the freeze even though the access is still missing
    assign w_timeout = (r_state == MEM_WAIT) && !bus.mem_ready_M &&
                       (r_wait_cnt == WC_W'(MAX_WAIT - 1));
    assign w_freeze  = w_mw && !w_timeout;

    // Priority-resolved pipeline controls; reset forces a flushed, unstalled front end
    always_comb begin
        w_ctl = 7'b000_0000;
        if (!rst) begin
            w_ctl = pack_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end else if (w_freeze) begin
            w_ctl = pack_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        end else if (bus.branch_taken_E) begin
            w_ctl = pack_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end else if (w_lu) begin
            w_ctl = pack_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end else begin
            w_ctl = 7'b000_0000;
        end
    end

    // Next-state decode for the memory-wait FSM
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (w_mw) begin
                    w_next_state = MEM_WAIT;
                end else begin
                    w_next_state = RUN;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready_M || w_timeout) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = MEM_WAIT;
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    // State register and wait counter, which restarts from zero on every entry to MEM_WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_wait_cnt <= {WC_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            if ((r_state == MEM_WAIT) && (w_next_state == MEM_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + WC_W'(1);
            end else begin
                r_wait_cnt <= {WC_W{1'b0}};
            end
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_err <= 1'b0;
        end else if (w_timeout) begin
            r_mem_err <= 1'b1;
        end else begin
            r_mem_err <= r_mem_err;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_ctl[6]),
        .count (w_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_ctl[1]),
        .count (w_flush_cnt)
    );

    assign bus.stall_F   = w_ctl[6];
    assign bus.stall_D   = w_ctl[5];
    assign bus.stall_E   = w_ctl[4];
    assign bus.stall_M   = w_ctl[3];
    assign bus.flush_D   = w_ctl[2];
    assign bus.flush_E   = w_ctl[1];
    assign bus.flush_W   = w_ctl[0];
    assign bus.mem_err   = r_mem_err;
    assign bus.stall_cnt = w_stall_cnt;
    assign bus.flush_cnt = w_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a behavioural reference predicts each cycle's controls and counters.
module tb_hazard_ctrl;

    localparam int MAXW = 16;

    typedef struct packed {
        logic [6:0]  ctl;
        logic        err;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [3:0]  sc4;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    bit          m_wait;
    int          m_wcnt;
    bit          m_err;
    longint      m_sc;
    longint      m_fc;
    int          m_sc4;

    hazard_ctrl_if                bus  ();
    hazard_ctrl_if #(.CNT_W(4))   bus4 ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        logic [6:0] obs;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            obs = {bus.stall_F, bus.stall_D, bus.stall_E, bus.stall_M,
                   bus.flush_D, bus.flush_E, bus.flush_W};
            chk({tag, "_ctl"}, 64'(obs), 64'(e.ctl));
            chk({tag, "_err"}, 64'(bus.mem_err), 64'(e.err));
            chk({tag, "_scnt"}, 64'(bus.stall_cnt), 64'(e.sc));
            chk({tag, "_fcnt"}, 64'(bus.flush_cnt), 64'(e.fc));
            chk({tag, "_scnt4"}, 64'(bus4.stall_cnt), 64'(e.sc4));
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mrd, input logic br, input logic req, input logic rdy);
        bus.rs1_D = rs1;  bus.rs2_D = rs2;  bus.rd_E = rd;
        bus.mem_read_E = mrd;  bus.branch_taken_E = br;
        bus.mem_req_M = req;   bus.mem_ready_M = rdy;
        bus4.rs1_D = rs1; bus4.rs2_D = rs2; bus4.rd_E = rd;
        bus4.mem_read_E = mrd; bus4.branch_taken_E = br;
        bus4.mem_req_M = req;  bus4.mem_ready_M = rdy;
    endtask

    // One pipeline cycle: entered and left at posedge+1
    task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic mrd, input logic br,
                        input logic req, input logic rdy);
        exp_t e;
        bit   lu;
        bit   mw;
        bit   to;
        drive(rs1, rs2, rd, mrd, br, req, rdy);
        lu = mrd && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        mw = req && !rdy;
        to = m_wait && (m_wcnt == MAXW - 1) && !rdy;
        if (mw && !to)   e.ctl = 7'b1111_001;
        else if (br)     e.ctl = 7'b0000_110;
        else if (lu)     e.ctl = 7'b1100_010;
        else             e.ctl = 7'b0000_000;
        e.err = m_err;
        e.sc  = 32'(m_sc);
        e.fc  = 32'(m_fc);
        e.sc4 = 4'(m_sc4);
        sb_q.push_back(e);
        #3;
        compare_head(tag);
        @(posedge clk);
        if (e.ctl[6]) begin
            m_sc  = (m_sc  == 64'hFFFF_FFFF) ? m_sc : m_sc + 1;
            m_sc4 = (m_sc4 == 15) ? 15 : m_sc4 + 1;
        end
        if (e.ctl[1]) m_fc = (m_fc == 64'hFFFF_FFFF) ? m_fc : m_fc + 1;
        if (to) m_err = 1'b1;
        if (!m_wait) begin
            if (mw) begin
                m_wait = 1'b1;
                m_wcnt = 0;
            end
        end else if (rdy || to) begin
            m_wait = 1'b0;
        end else begin
            m_wcnt++;
        end
        #1;
    endtask

    // Assert reset mid-cycle without touching the inputs, check reset outputs, release after an edge
    task automatic do_reset(input string tag);
        exp_t e;
        rst = 1'b0;
        e.ctl = 7'b0000_110;
        e.err = 1'b0;
        e.sc  = 32'd0;
        e.fc  = 32'd0;
        e.sc4 = 4'd0;
        sb_q.push_back(e);
        #2;
        compare_head(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_wait = 1'b0; m_wcnt = 0; m_err = 1'b0;
        m_sc = 0; m_fc = 0; m_sc4 = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        do_reset("rst0");

        step("lu",      5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_post", 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_rs2",  5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_x0",   5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("no_dep",  5'd3, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);

        step("br",      5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("br_lu",   5'd6, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step("br_post", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) step("mw3", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mw3_rdy",  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("mw3_idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        do_reset("rst_to");
        for (int i = 0; i < MAXW + 1; i++) step("tmo", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("tmo_idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        do_reset("rst_brw");
        for (int i = 0; i < 2; i++) step("brw", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("brw_rel",  5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("brw_idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) step("rmw", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset("rst_mid");
        step("rmw_rerun", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rmw_rdy",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 60; i++) begin
            step("rnd", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)));
        end

        do_reset("rst_sat");
        for (int i = 0; i < 20; i++) step("sat", 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("sat_idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_hold15", 64'(bus4.stall_cnt), 64'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
